// File: rtl/sev_seg_arbiter.sv
// Round-robin owner arbitration for a shared 4-digit BCD display, with a
// guaranteed minimum hold time per owner and a registered digit datapath.
module sev_seg_arbiter #(
  parameter int         N_REQ       = 3,
  parameter int         HOLD_CYCLES = 50000000,
  parameter int         CNT_W       = 26,
  parameter logic [3:0] IDLE_CODE   = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     grant,
  output logic [2:0]           owner_idx,
  output logic [3:0]           digit_0,
  output logic [3:0]           digit_1,
  output logic [3:0]           digit_2,
  output logic [3:0]           digit_3,
  output logic                 disp_valid,
  output logic                 switch_pulse,
  output logic                 bad_digit,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_t;

  localparam logic [N_REQ-1:0] GRANT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]       LAST_RST  = 3'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               switch_q, switch_d;
  logic               bad_q, bad_d;
  logic [3:0]         dig_q [4];
  logic [3:0]         dig_d [4];

  // Requests and data widened to the full 8-requester space so a 3-bit
  // index is always in range regardless of N_REQ.
  logic [7:0]         req_ext;
  logic [127:0]       data_ext;
  logic [15:0]        sel_data;
  logic [7:0]         owner_mask;
  logic               owner_req;
  logic               others_req;

  logic [3:0]         cand;
  logic               pick_found;
  logic [2:0]         pick_idx;
  logic               take;
  logic               go_idle;
  logic               bad_now;

  assign req_ext    = 8'(req);
  assign data_ext   = 128'(req_data);
  assign sel_data   = data_ext[{owner_q, 4'b0000} +: 16];
  assign owner_mask = 8'd1 << owner_q;
  assign owner_req  = req_ext[owner_q];
  assign others_req = |(req_ext & ~owner_mask);

  // Search starts just after last_owner, so the current owner is seen last.
  always_comb begin
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = {1'b0, last_q} + 4'(off);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!pick_found && req_ext[cand[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    switch_d = 1'b0;
    take     = 1'b0;
    go_idle  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) take = 1'b1;
      end
      ST_HOLD: begin
        if (!owner_req) begin
          if (others_req) take = 1'b1;
          else            go_idle = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_OPEN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OPEN: begin
        if (others_req)      take    = 1'b1;
        else if (!owner_req) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (take) begin
      state_d  = ST_HOLD;
      grant_d  = GRANT_ONE << pick_idx;
      owner_d  = pick_idx;
      last_d   = pick_idx;
      cnt_d    = '0;
      valid_d  = 1'b1;
      switch_d = 1'b1;
    end
    if (go_idle) begin
      state_d  = ST_IDLE;
      grant_d  = '0;
      owner_d  = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      switch_d = 1'b1;
    end
  end

  // Digits follow the registered owner, giving one cycle of grant-to-digit latency.
  always_comb begin
    bad_now = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dig_d[k] = IDLE_CODE;
      if (valid_q) begin
        dig_d[k] = sel_data[4*k +: 4];
        if (sel_data[4*k +: 4] > 4'd9) bad_now = 1'b1;
      end
    end
    bad_d = bad_q | bad_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      last_q   <= LAST_RST;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
      bad_q    <= 1'b0;
      for (int k = 0; k < 4; k++) dig_q[k] <= IDLE_CODE;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      switch_q <= switch_d;
      bad_q    <= bad_d;
      for (int k = 0; k < 4; k++) dig_q[k] <= dig_d[k];
    end
  end

  assign grant        = grant_q;
  assign owner_idx    = owner_q;
  assign disp_valid   = valid_q;
  assign switch_pulse = switch_q;
  assign bad_digit    = bad_q;
  assign digit_0      = dig_q[0];
  assign digit_1      = dig_q[1];
  assign digit_2      = dig_q[2];
  assign digit_3      = dig_q[3];
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sev_seg_arbiter.sv
// Directed bench for sev_seg_arbiter with a short hold time (4 cycles) so
// hold, rotation, drop, bad-digit and async reset behaviour are all reachable.
module tb_sev_seg_arbiter;

  localparam int N_REQ = 3;
  localparam int HOLD  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_OPEN = 2'd2;

  logic                clk;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    grant;
  logic [2:0]          owner_idx;
  logic [3:0]          digit_0, digit_1, digit_2, digit_3;
  logic                disp_valid;
  logic                switch_pulse;
  logic                bad_digit;
  logic [1:0]          state_dbg;
  logic [15:0]         digs;

  int n_chk;
  int n_pass;
  int pulses;

  assign digs = {digit_3, digit_2, digit_1, digit_0};

  sev_seg_arbiter #(
    .N_REQ(N_REQ), .HOLD_CYCLES(HOLD), .CNT_W(3), .IDLE_CODE(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .owner_idx(owner_idx),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .disp_valid(disp_valid), .switch_pulse(switch_pulse),
    .bad_digit(bad_digit), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_grant"},  32'(grant), 32'h0);
    check_eq({tag, "_owner"},  32'(owner_idx), 32'h0);
    check_eq({tag, "_valid"},  32'(disp_valid), 32'h0);
    check_eq({tag, "_switch"}, 32'(switch_pulse), 32'h0);
    check_eq({tag, "_bad"},    32'(bad_digit), 32'h0);
    check_eq({tag, "_digits"}, 32'(digs), 32'hFFFF);
    check_eq({tag, "_state"},  32'(state_dbg), 32'(S_IDLE));
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    pulses   = 0;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    step(3);
    check_reset_values("rst");

    // first grant: req1 and req2 high, requester 1 wins after last_owner=2
    rst_n = 1'b1;
    req   = 3'b110;
    req_data[31:16] = 16'h1234;
    req_data[47:32] = 16'h5678;
    step(1);
    check_eq("g1_grant",  32'(grant), 32'h2);
    check_eq("g1_owner",  32'(owner_idx), 32'h1);
    check_eq("g1_valid",  32'(disp_valid), 32'h1);
    check_eq("g1_switch", 32'(switch_pulse), 32'h1);
    check_eq("g1_digits_lat", 32'(digs), 32'hFFFF);
    check_eq("g1_state",  32'(state_dbg), 32'(S_HOLD));
    step(1);
    check_eq("g1_switch_off", 32'(switch_pulse), 32'h0);
    check_eq("g1_digits", 32'(digs), 32'h1234);

    // req2 pending through the hold window; switch only after OPEN
    step(3);
    check_eq("hold_grant", 32'(grant), 32'h2);
    check_eq("hold_open",  32'(state_dbg), 32'(S_OPEN));
    step(1);
    check_eq("sw2_grant",  32'(grant), 32'h4);
    check_eq("sw2_owner",  32'(owner_idx), 32'h2);
    check_eq("sw2_switch", 32'(switch_pulse), 32'h1);
    step(1);
    check_eq("sw2_digits", 32'(digs), 32'h5678);

    // sole owner drops mid-HOLD -> IDLE, digits blank one edge later
    req = 3'b100;
    step(1);
    req = 3'b000;
    step(1);
    check_eq("drop_grant",  32'(grant), 32'h0);
    check_eq("drop_valid",  32'(disp_valid), 32'h0);
    check_eq("drop_switch", 32'(switch_pulse), 32'h1);
    check_eq("drop_digits_lat", 32'(digs), 32'h5678);
    step(1);
    check_eq("drop_digits", 32'(digs), 32'hFFFF);
    check_eq("drop_state",  32'(state_dbg), 32'(S_IDLE));

    // all three requesting: 0,1,2,0 each held 5 cycles
    req = 3'b111;
    req_data[15:0] = 16'h0987;
    step(1);
    check_eq("rr0_grant",  32'(grant), 32'h1);
    check_eq("rr0_switch", 32'(switch_pulse), 32'h1);
    step(4);
    check_eq("rr0_held",   32'(grant), 32'h1);
    check_eq("rr0_quiet",  32'(switch_pulse), 32'h0);
    step(1);
    check_eq("rr1_grant",  32'(grant), 32'h2);
    step(1);
    check_eq("rr1_digits", 32'(digs), 32'h1234);
    step(3);
    check_eq("rr1_held",   32'(grant), 32'h2);
    step(1);
    check_eq("rr2_grant",  32'(grant), 32'h4);
    step(4);
    check_eq("rr2_held",   32'(grant), 32'h4);
    step(1);
    check_eq("rr3_grant",  32'(grant), 32'h1);
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (switch_pulse) pulses++;
    end
    check_eq("rr_pulses", 32'(pulses), 32'd3);
    check_eq("rr4_grant", 32'(grant), 32'h1);
    step(5);
    check_eq("rr5_grant", 32'(grant), 32'h2);

    // owner 1 drops while req0 is high -> direct switch, no idle cycle
    req = 3'b001;
    step(1);
    check_eq("dsw_grant", 32'(grant), 32'h1);
    check_eq("dsw_valid", 32'(disp_valid), 32'h1);
    check_eq("dsw_state", 32'(state_dbg), 32'(S_HOLD));

    // non-BCD nibble forwarded and flagged; flag is sticky
    req_data[15:0] = 16'h00A5;
    step(1);
    check_eq("bad_digit1", 32'(digit_1), 32'hA);
    check_eq("bad_set",    32'(bad_digit), 32'h1);
    req_data[15:0] = 16'h0012;
    step(1);
    check_eq("bad_digits_live", 32'(digs), 32'h0012);
    check_eq("bad_sticky", 32'(bad_digit), 32'h1);

    // asynchronous reset mid-HOLD, observed before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("arst");
    step(1);
    rst_n = 1'b1;
    req   = 3'b011;
    step(1);
    check_eq("post_rst_grant", 32'(grant), 32'h1);
    check_eq("post_rst_owner", 32'(owner_idx), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
